// File: rtl/stream_pkg.sv
// stream_pkg: shared constants and helpers for the stream concentrator.
// Mode encodings and channel-index/entry width helpers.
package stream_pkg;

    localparam int MODE_MERGE = 0;
    localparam int MODE_XOR   = 1;

    // Channel-index width: max(1, clog2(n)).
    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Width of one buffered entry {chan, data}.
    function automatic int entry_w(input int w, input int n);
        return w + chan_w(n);
    endfunction

endpackage

// File: rtl/stream.sv
// Shared interfaces: plain data bus and valid/ready stream.
// stream adds handshaking on top of the simple data-only bus.
interface simple #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    modport tx (output data);
    modport rx (input data);
endinterface

interface stream #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    modport tx (output data, valid, input ready);
    modport rx (input data, valid, output ready);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: circular buffer with registered occupancy count.
// Head entry is read straight from storage; no bypass path.
module stream_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rp];

    // Storage, pointers and occupancy; reset clears all contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/stream_merge.sv
// stream_merge: NCHAN-input concentrator into one buffered stream.
// Mode 0 round-robin merges with channel tag; mode 1 XOR-combines.
module stream_merge
    import stream_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCHAN = 2,
    parameter  int DEPTH = 4,
    parameter  int MODE  = 0,
    localparam int CW    = chan_w(NCHAN),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    stream.rx             in [NCHAN-1:0],
    stream.tx             out,
    output logic [CW-1:0] out_chan,
    output logic [LW-1:0] level
);

    typedef struct packed {
        logic [CW-1:0]    chan;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [NCHAN-1:0] valid;
    logic [NCHAN-1:0] ready;
    logic [WIDTH-1:0] data [NCHAN];
    logic [CW-1:0]    rr;
    logic [CW-1:0]    grant;
    logic             gvalid;
    int               idx;
    logic [WIDTH-1:0] xr;
    logic             allv;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    entry_t           wentry;
    entry_t           rentry;

    for (genvar i = 0; i < NCHAN; i++) begin : g_ch
        assign valid[i]    = in[i].valid;
        assign data[i]     = in[i].data;
        assign in[i].ready = ready[i];
    end

    // Rotating-priority search starting at rr; lowest offset wins.
    always_comb begin
        grant  = rr;
        gvalid = 1'b0;
        idx    = 0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= NCHAN) begin
                idx = idx - NCHAN;
            end
            if (valid[idx]) begin
                grant  = CW'(idx);
                gvalid = 1'b1;
            end
        end
    end

    // XOR of every channel word for combine mode.
    always_comb begin
        xr = '0;
        for (int i = 0; i < NCHAN; i++) begin
            xr = xr ^ data[i];
        end
    end

    assign allv   = &valid;
    assign accept = rst & ~full;

    // Input ready: only the granted channel, or all at once in XOR mode.
    always_comb begin
        ready = '0;
        if (accept) begin
            if (MODE == MODE_XOR) begin
                ready = {NCHAN{allv}};
            end else if (gvalid) begin
                ready[grant] = 1'b1;
            end
        end
    end

    assign push = |(ready & valid);
    assign pop  = out.valid & out.ready;

    // Entry written into the buffer for the accepted transfer.
    always_comb begin
        if (MODE == MODE_XOR) begin
            wentry.chan = '0;
            wentry.data = xr;
        end else begin
            wentry.chan = grant;
            wentry.data = data[grant];
        end
    end

    // Advance the round-robin pointer past the channel just served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= '0;
        end else if (MODE == MODE_MERGE && push) begin
            rr <= (grant == CW'(NCHAN - 1)) ? '0 : grant + 1'b1;
        end
    end

    stream_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (rentry),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out.valid = ~empty;
    assign out.data  = rentry.data;
    assign out_chan  = rentry.chan;

endmodule

// File: tb/tb_stream_merge.sv
// tb_stream_merge: directed scoreboard bench for stream_merge.
// Merge instance (4 ch) and XOR instance (2 ch) share clock and reset.
module tb_stream_merge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    stream #(.WIDTH(32)) i0 [3:0] ();
    stream #(.WIDTH(32)) o0 ();
    stream #(.WIDTH(32)) i1 [1:0] ();
    stream #(.WIDTH(32)) o1 ();

    logic [3:0]  v0;
    logic [3:0]  rdy0;
    logic [31:0] d0 [4];
    logic        ordy0;
    logic [1:0]  chan0;
    logic [2:0]  lvl0;

    logic [1:0]  v1;
    logic [1:0]  rdy1;
    logic [31:0] d1 [2];
    logic        ordy1;
    logic        chan1;
    logic [2:0]  lvl1;

    logic [33:0] exp0 [$];
    logic [32:0] exp1 [$];

    for (genvar g = 0; g < 4; g++) begin : g_i0
        assign i0[g].valid = v0[g];
        assign i0[g].data  = d0[g];
        assign rdy0[g]     = i0[g].ready;
    end

    for (genvar g = 0; g < 2; g++) begin : g_i1
        assign i1[g].valid = v1[g];
        assign i1[g].data  = d1[g];
        assign rdy1[g]     = i1[g].ready;
    end

    assign o0.ready = ordy0;
    assign o1.ready = ordy1;

    stream_merge #(
        .WIDTH(32), .NCHAN(4), .DEPTH(4), .MODE(0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .in       (i0),
        .out      (o0),
        .out_chan (chan0),
        .level    (lvl0)
    );

    stream_merge #(
        .WIDTH(32), .NCHAN(2), .DEPTH(4), .MODE(1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in       (i1),
        .out      (o1),
        .out_chan (chan1),
        .level    (lvl1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Merge-instance monitor: compare each delivered word with the queue.
    always @(negedge clk) begin
        if (rst === 1'b1 && o0.valid === 1'b1 && ordy0 === 1'b1) begin
            if (exp0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m0_unexpected: got %0h expected none",
                         {chan0, o0.data});
            end else begin
                chk("m0_word", 64'({chan0, o0.data}), 64'(exp0.pop_front()));
            end
        end
    end

    // XOR-instance monitor.
    always @(negedge clk) begin
        if (rst === 1'b1 && o1.valid === 1'b1 && ordy1 === 1'b1) begin
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m1_unexpected: got %0h expected none",
                         {chan1, o1.data});
            end else begin
                chk("m1_word", 64'({chan1, o1.data}), 64'(exp1.pop_front()));
            end
        end
    end

    // One merge transfer on channel g: expect only g ready, queue the
    // word, let the edge take it, then present that channel's next word.
    task automatic xfer0(input int g);
        #1;
        chk("grant", 64'(rdy0), 64'(4'b0001 << g));
        exp0.push_back({2'(g), d0[g]});
        @(posedge clk);
        #1;
        d0[g] = d0[g] + 32'h0000_0100;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        ordy0 = 1'b1;
        ordy1 = 1'b1;
        v0    = 4'hF;
        v1    = 2'b00;
        for (int i = 0; i < 4; i++) d0[i] = 32'hA000_0000 + 32'(i * 16);
        d1[0] = '0;
        d1[1] = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_ready0", 64'(rdy0), 64'(0));
            chk("rst_valid0", 64'(o0.valid), 64'(0));
            chk("rst_level0", 64'(lvl0), 64'(0));
            chk("rst_data0", 64'(o0.data), 64'(0));
            chk("rst_chan0", 64'(chan0), 64'(0));
            chk("rst_level1", 64'(lvl1), 64'(0));
        end
        rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            xfer0(k % 4);
            if (k == 0) chk("first_valid", 64'(o0.valid), 64'(1));
            chk("rot_level_le1", 64'(lvl0 <= 3'd1), 64'(1));
        end
        v0 = 4'b0000;
        repeat (2) @(posedge clk);
        #1;

        v0 = 4'b0010;
        xfer0(1);
        v0 = 4'b1010;
        xfer0(3);
        xfer0(1);
        xfer0(3);
        xfer0(1);
        v0 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_level", 64'(lvl0), 64'(0));

        ordy0 = 1'b0;
        v0    = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            xfer0(0);
            chk("fill_level", 64'(lvl0), 64'(k + 1));
        end
        chk("full_ready", 64'(rdy0), 64'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("full_hold_ready", 64'(rdy0), 64'(0));
            chk("full_hold_level", 64'(lvl0), 64'(4));
        end
        ordy0 = 1'b1;
        @(posedge clk);
        #1;
        chk("pop_level", 64'(lvl0), 64'(3));
        chk("ready_back", 64'(rdy0), 64'(1));
        xfer0(0);
        v0 = 4'b0000;
        repeat (6) @(posedge clk);
        #1;
        chk("full_drain", 64'(lvl0), 64'(0));

        v1    = 2'b01;
        d1[0] = 32'h0000_55AA;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("xor_partial_ready", 64'(rdy1), 64'(0));
            chk("xor_partial_level", 64'(lvl1), 64'(0));
        end
        d1[1] = 32'h0000_FFFF;
        v1    = 2'b11;
        #1;
        chk("xor_ready", 64'(rdy1), 64'(2'b11));
        exp1.push_back({1'b0, 32'h0000_AA55});
        @(posedge clk);
        #1;
        v1 = 2'b00;
        chk("xor_level", 64'(lvl1), 64'(1));
        d1[0] = 32'h1234_5678;
        d1[1] = 32'hFFFF_0000;
        v1    = 2'b11;
        exp1.push_back({1'b0, 32'hEDCB_5678});
        @(posedge clk);
        #1;
        v1 = 2'b10;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("xor_ch1_only_ready", 64'(rdy1), 64'(0));
        end
        v1 = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("xor_drain", 64'(lvl1), 64'(0));

        ordy0 = 1'b0;
        v0    = 4'b0001;
        repeat (3) xfer0(0);
        v0 = 4'b0000;
        chk("pre_rst_level", 64'(lvl0), 64'(3));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_level", 64'(lvl0), 64'(0));
        chk("async_valid", 64'(o0.valid), 64'(0));
        chk("async_data", 64'(o0.data), 64'(0));
        chk("async_chan", 64'(chan0), 64'(0));
        exp0.delete();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        ordy0 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_stale", 64'(o0.valid), 64'(0));
        end
        v0 = 4'b0001;
        xfer0(0);
        v0 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;

        chk("exp0_empty", 64'(exp0.size()), 64'(0));
        chk("exp1_empty", 64'(exp1.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
